// File: rtl/cod_pkg.sv
// Shared definitions for the pipeline hazard logic.
//   FWD_*  : ALU operand source selects driven on fwd_a / fwd_b.
//   st_t   : hazard responder run/halt state.
package cod_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;  // operand from the register file
    localparam logic [1:0] FWD_W    = 2'b01;  // operand from the W-stage result
    localparam logic [1:0] FWD_M    = 2'b10;  // operand from the M-stage result

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } st_t;

endpackage

// File: rtl/hz_fwd_sel.sv
// Forwarding comparator for one E-stage source operand.
//   rs_e        : source register of the E instruction
//   rd_m, we_m  : destination and write enable of the M instruction
//   rd_w, we_w  : destination and write enable of the W instruction
//   fwd         : FWD_M, FWD_W or FWD_NONE; M wins when both match
// A zero destination never matches because x0 is hard-wired.
module hz_fwd_sel
    import cod_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       we_m,
    input  logic [4:0] rd_w,
    input  logic       we_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_NONE;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard responder for the five-stage RV32I core.
//   clk, rstn                  : clock, synchronous active-low reset
//   rs1_d, rs2_d, rd_d         : register fields of the D instruction
//   use_rs1_d, use_rs2_d       : D instruction really reads rs1 / rs2
//   memread_e                  : E instruction is a load
//   regwrite_e/_m/_w           : register-write enables of E, M, W
//   taken_e                    : branch/jump in E redirects the PC
//   stop                       : ecall halt request
//   stall_f, stall_d           : hold PC and F/D register
//   eflush                     : bubble into D->E
//   flush                      : kill F, D and E (M->W kept)
//   fwd_a, fwd_b               : E-stage ALU operand sources
//   stall_cnt, flush_cnt       : saturating load-use / flush counters
module hazard_unit
    import cod_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic            use_rs1_d,
    input  logic            use_rs2_d,
    input  logic            memread_e,
    input  logic            regwrite_e,
    input  logic            regwrite_m,
    input  logic            regwrite_w,
    input  logic            taken_e,
    input  logic            stop,
    output logic            stall_f,
    output logic            stall_d,
    output logic            eflush,
    output logic            flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
);

    st_t        st;
    st_t        st_nxt;

    logic [4:0] rd_e;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic       we_e;
    logic [4:0] rd_m;
    logic       we_m;
    logic [4:0] rd_w;
    logic       we_w;

    logic       lu;
    logic       cnt_stall;
    logic       cnt_flush;

    assign lu = memread_e && (rd_e != 5'd0) &&
                ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st <= ST_RUN;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt  = st;
        stall_f = 1'b0;
        stall_d = 1'b0;
        eflush  = 1'b0;
        flush   = 1'b0;
        case (st)
            ST_RUN: begin
                if (stop) begin
                    st_nxt = ST_HALT;
                end
                // A taken redirect kills the dependent D instruction anyway,
                // so it overrides any load-use stall.
                if (taken_e) begin
                    flush = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    eflush  = 1'b1;
                end
            end
            ST_HALT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                eflush  = 1'b1;
            end
            default: st_nxt = ST_RUN;
        endcase
    end

    // we_e marks a real instruction entering E; the controller's per-stage
    // regwrite bits then qualify it as it moves down the pipe, so bubbles
    // and non-writing instructions never forward.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_e  <= '0;
            rs1_e <= '0;
            rs2_e <= '0;
            we_e  <= 1'b0;
            rd_m  <= '0;
            we_m  <= 1'b0;
            rd_w  <= '0;
            we_w  <= 1'b0;
        end else begin
            rd_w <= rd_m;
            we_w <= we_m && regwrite_m;
            if (flush) begin
                rd_e  <= '0;
                rs1_e <= '0;
                rs2_e <= '0;
                we_e  <= 1'b0;
                rd_m  <= '0;
                we_m  <= 1'b0;
            end else if (eflush) begin
                rd_e  <= '0;
                rs1_e <= '0;
                rs2_e <= '0;
                we_e  <= 1'b0;
                rd_m  <= rd_e;
                we_m  <= we_e && regwrite_e;
            end else begin
                rd_e  <= rd_d;
                rs1_e <= rs1_d;
                rs2_e <= rs2_d;
                we_e  <= 1'b1;
                rd_m  <= rd_e;
                we_m  <= we_e && regwrite_e;
            end
        end
    end

    // Only a stall actually caused by a load-use counts; HALT freezes both.
    assign cnt_stall = (st == ST_RUN) && !taken_e && lu;
    assign cnt_flush = (st == ST_RUN) && taken_e;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (cnt_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + XLEN'(1);
            end
            if (cnt_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + XLEN'(1);
            end
        end
    end

    hz_fwd_sel u_fwd_a (
        .rs_e (rs1_e),
        .rd_m (rd_m),
        .we_m (we_m),
        .rd_w (rd_w),
        .we_w (we_w && regwrite_w),
        .fwd  (fwd_a)
    );

    hz_fwd_sel u_fwd_b (
        .rs_e (rs2_e),
        .rd_m (rd_m),
        .we_m (we_m),
        .rd_w (rd_w),
        .we_w (we_w && regwrite_w),
        .fwd  (fwd_b)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: instruction-level pipeline model
// (one record per stage) drives the controller bits and predicts outputs.
module tb_hazard_unit;

    localparam int W   = 4;
    localparam int SAT = 15;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       wr;
        logic       ld;
    } ins_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [4:0]   rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic         use_rs1_d = 1'b0, use_rs2_d = 1'b0;
    logic         memread_e = 1'b0;
    logic         regwrite_e = 1'b0, regwrite_m = 1'b0, regwrite_w = 1'b0;
    logic         taken_e = 1'b0, stop = 1'b0;
    logic         stall_f, stall_d, eflush, flush;
    logic [1:0]   fwd_a, fwd_b;
    logic [W-1:0] stall_cnt, flush_cnt;

    hazard_unit #(.XLEN(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .memread_e  (memread_e),
        .regwrite_e (regwrite_e),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .taken_e    (taken_e),
        .stop       (stop),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .eflush     (eflush),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    ins_t e_s, m_s, w_s;
    bit   halted;
    int   stall_m, flush_m;
    ins_t cur_d;
    bit   cur_stop;
    bit   x_lu, x_flush, x_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                                input bit u1, input bit u2, input bit wr, input bit ld);
        ins_t i;
        i.v   = 1'b1;
        i.rd  = 5'(rd);
        i.rs1 = 5'(rs1);
        i.rs2 = 5'(rs2);
        i.u1  = u1;
        i.u2  = u2;
        i.wr  = wr;
        i.ld  = ld;
        return i;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ins_t rnd_ins();
        bit ld;
        ld = ($urandom_range(0, 9) < 4);
        return mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), ld || ($urandom_range(0, 3) != 0), ld);
    endfunction

    function automatic bit writes_to(input ins_t p, input logic [4:0] r);
        return p.v && p.wr && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic [1:0] src_for(input logic [4:0] r);
        if (!e_s.v) return 2'b00;
        if (writes_to(m_s, r)) return 2'b10;
        if (writes_to(w_s, r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic drive(input ins_t d, input bit taken, input bit stp);
        cur_d      = d;
        cur_stop   = stp;
        rs1_d      = d.rs1;
        rs2_d      = d.rs2;
        rd_d       = d.rd;
        use_rs1_d  = d.u1;
        use_rs2_d  = d.u2;
        memread_e  = e_s.v && e_s.ld;
        regwrite_e = e_s.v && e_s.wr;
        regwrite_m = m_s.v && m_s.wr;
        regwrite_w = w_s.v && w_s.wr;
        taken_e    = taken;
        stop       = stp;
        #2;
        x_lu = e_s.v && e_s.ld && (e_s.rd != 5'd0) &&
               ((d.u1 && d.rs1 == e_s.rd) || (d.u2 && d.rs2 == e_s.rd));
        if (halted) begin
            x_flush = 1'b0;
            x_stall = 1'b1;
        end else begin
            x_flush = taken;
            x_stall = !taken && x_lu;
        end
        check("stall_f",   32'(stall_f),   32'(x_stall));
        check("stall_d",   32'(stall_d),   32'(x_stall));
        check("eflush",    32'(eflush),    32'(x_stall));
        check("flush",     32'(flush),     32'(x_flush));
        check("fwd_a",     32'(fwd_a),     32'(src_for(e_s.rs1)));
        check("fwd_b",     32'(fwd_b),     32'(src_for(e_s.rs2)));
        check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        check("flush_cnt", 32'(flush_cnt), 32'(flush_m));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!halted) begin
            if (x_flush) flush_m = sat_inc(flush_m);
            else if (x_stall) stall_m = sat_inc(stall_m);
        end
        if (x_flush) begin
            w_s = m_s;
            m_s = '0;
            e_s = '0;
        end else if (x_stall) begin
            w_s = m_s;
            m_s = e_s;
            e_s = '0;
        end else begin
            w_s = m_s;
            m_s = e_s;
            e_s = cur_d;
        end
        if (cur_stop) halted = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        e_s = '0;
        m_s = '0;
        w_s = '0;
        halted  = 1'b0;
        stall_m = 0;
        flush_m = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        ins_t d;
        bit   hold;
        int   f0, s0;

        e_s = '0; m_s = '0; w_s = '0;
        halted = 1'b0; stall_m = 0; flush_m = 0;
        @(negedge clk);
        do_reset();

        // reset state
        drive(nop(), 0, 0);
        check("rst_fwd_a", 32'(fwd_a), 32'(0));
        check("rst_cnt",   32'(stall_cnt), 32'(0));
        tick();

        // back-to-back dependency -> M forward, one apart -> W forward
        drive(mk(5, 1, 2, 1, 1, 1, 0), 0, 0); tick();
        drive(mk(6, 5, 5, 1, 1, 1, 0), 0, 0); tick();
        drive(mk(8, 1, 2, 1, 1, 1, 0), 0, 0);
        check("dep_fwd_a_m", 32'(fwd_a), 32'(2'b10));
        check("dep_fwd_b_m", 32'(fwd_b), 32'(2'b10));
        tick();
        drive(mk(10, 1, 2, 1, 1, 1, 0), 0, 0); tick();
        drive(mk(9, 8, 8, 1, 1, 1, 0), 0, 0); tick();
        drive(nop(), 0, 0);
        check("dep_fwd_a_w", 32'(fwd_a), 32'(2'b01));
        check("dep_fwd_b_w", 32'(fwd_b), 32'(2'b01));
        tick();

        // load-use: one stall cycle, then W forward
        drive(mk(7, 1, 0, 1, 0, 1, 1), 0, 0); tick();
        drive(mk(11, 7, 3, 1, 1, 1, 0), 0, 0);
        check("lu_stall", 32'({stall_f, stall_d, eflush}), 32'(3'b111));
        tick();
        drive(mk(11, 7, 3, 1, 1, 1, 0), 0, 0);
        check("lu_once", 32'(eflush), 32'(0));
        tick();
        drive(nop(), 0, 0);
        check("lu_fwd_w", 32'(fwd_a), 32'(2'b01));
        check("lu_cnt",   32'(stall_cnt), 32'(1));
        tick();

        // x0 writer and reader: no forward, no stall
        drive(mk(0, 1, 2, 1, 1, 1, 1), 0, 0); tick();
        drive(mk(12, 0, 0, 1, 1, 1, 0), 0, 0);
        check("x0_nostall", 32'(stall_f), 32'(0));
        tick();
        drive(nop(), 0, 0);
        check("x0_fwd", 32'(fwd_a), 32'(2'b00));
        tick();

        // taken together with load-use
        drive(mk(13, 1, 0, 1, 0, 1, 1), 0, 0); tick();
        f0 = flush_m; s0 = stall_m;
        drive(mk(14, 13, 13, 1, 1, 1, 0), 1, 0);
        check("tk_flush",  32'(flush), 32'(1));
        check("tk_eflush", 32'(eflush), 32'(0));
        tick();
        drive(nop(), 0, 0);
        check("tk_fcnt", 32'(flush_cnt), 32'(f0 + 1));
        check("tk_scnt", 32'(stall_cnt), 32'(s0));
        tick();

        // randomized traffic
        hold = 1'b0;
        d = rnd_ins();
        for (int i = 0; i < 500; i++) begin
            if (!hold) d = rnd_ins();
            drive(d, ($urandom_range(0, 9) == 0), 0);
            hold = x_stall;
            tick();
        end

        // saturation of both counters
        for (int i = 0; i < 20; i++) begin
            drive(rnd_ins(), 1, 0); tick();
        end
        check("flush_sat", 32'(flush_cnt), 32'(SAT));
        for (int i = 0; i < 18; i++) begin
            drive(mk(3, 0, 0, 0, 0, 1, 1), 0, 0); tick();
            drive(mk(2, 3, 1, 1, 1, 1, 0), 0, 0); tick();
            drive(mk(2, 3, 1, 1, 1, 1, 0), 0, 0); tick();
        end
        check("stall_sat", 32'(stall_cnt), 32'(SAT));

        // reset while stalled
        do_reset();
        drive(mk(2, 0, 0, 0, 0, 1, 1), 0, 0); tick();
        drive(mk(4, 2, 2, 1, 1, 1, 0), 0, 0);
        check("pre_rst_stall", 32'(stall_f), 32'(1));
        do_reset();
        drive(nop(), 0, 0);
        check("post_rst_stall", 32'(stall_f), 32'(0));
        tick();

        // stop with taken in the same cycle, then absorbing HALT
        drive(mk(5, 1, 2, 1, 1, 1, 0), 0, 0); tick();
        drive(nop(), 1, 1);
        check("stop_flush", 32'(flush), 32'(1));
        tick();
        f0 = flush_m;
        for (int i = 0; i < 24; i++) begin
            drive(rnd_ins(), 1'($urandom), 1'($urandom));
            check("halt_stuck", 32'({stall_f, stall_d, eflush, flush}), 32'(4'b1110));
            tick();
        end
        check("halt_frozen", 32'(flush_cnt), 32'(f0));

        // reset from HALT, normal operation resumes
        do_reset();
        drive(nop(), 0, 0);
        check("rst_halt_out", 32'({stall_f, eflush, flush, fwd_a, fwd_b, stall_cnt, flush_cnt}), 32'(0));
        tick();
        drive(mk(5, 1, 2, 1, 1, 1, 0), 0, 0); tick();
        drive(mk(6, 5, 5, 1, 1, 1, 0), 0, 0); tick();
        drive(nop(), 0, 0);
        check("resume_fwd", 32'(fwd_b), 32'(2'b10));
        tick();
        for (int i = 0; i < 60; i++) begin
            if (!hold) d = rnd_ins();
            drive(d, ($urandom_range(0, 9) == 0), 0);
            hold = x_stall;
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
